instr_fetch_unit: RTL and testbench

Parametrised instruction fetch front-end that replaces the bare program counter plus instruction ROM pairing in `top`. It issues sequential fetch requests over a request/grant/response memory port and buffers returned instructions in a DEPTH-entry FIFO. It hands instructions to decode with a valid/ready handshake. A branch/jump redirect flushes the buffer and discards any in-flight responses.

---
 rtl/instr_fetch_unit.sv | 83 ++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch over a req/gnt/rvalid port with a DEPTH-entry
// instruction FIFO; a redirect flushes the FIFO and discards responses already in flight.
module instr_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0000_0000,
   parameter int DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic              gnt_i,
   input  logic              rvalid_i,
   input  logic [31:0]       rdata_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] instr_pc_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] LIMIT = DEPTH;
   logic [ADDR_W-1:0] fetch_pc;
   logic [31:0] instr_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem [DEPTH];
   logic [ADDR_W-1:0] pcq [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
   logic [CW-1:0] occ, live, drop;
   logic grant, discard, keep, push, pop;
   always_comb begin
      req_o = !rst_i && ({1'b0, occ} + {1'b0, live} < LIMIT) && ({1'b0, live} + {1'b0, drop} < LIMIT);
      addr_o = fetch_pc;
      grant = req_o && gnt_i;
      discard = rvalid_i && drop != '0;
      keep = rvalid_i && drop == '0 && live != '0;
      push = keep && !redirect_i;
      instr_valid_o = occ != '0;
      pop = instr_valid_o && instr_ready_i;
      instr_o = instr_valid_o ? instr_mem[rd_ptr] : '0;
      instr_pc_o = instr_valid_o ? pc_mem[rd_ptr] : '0;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         fetch_pc <= BOOT_ADDR;
         occ <= '0;
         live <= '0;
         drop <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         pq_rd <= '0;
         pq_wr <= '0;
      end else if (redirect_i) begin
         // everything granted so far, plus a grant this cycle, is now stale
         fetch_pc <= redirect_addr_i & ~ADDR_W'(3);
         occ <= '0;
         live <= '0;
         drop <= drop + live + CW'(grant) - CW'(discard || keep);
         rd_ptr <= '0;
         wr_ptr <= '0;
         pq_rd <= '0;
         pq_wr <= '0;
      end else begin
         if (grant) fetch_pc <= fetch_pc + ADDR_W'(4);
         if (grant) pq_wr <= pq_wr + PW'(1);
         if (push) pq_rd <= pq_rd + PW'(1);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         occ <= occ + CW'(push) - CW'(pop);
         live <= live + CW'(grant) - CW'(keep);
         drop <= drop - CW'(discard);
      end
   // storage needs no reset: occ gates every read
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_mem[wr_ptr] <= rdata_i;
         pc_mem[wr_ptr] <= pcq[pq_rd];
      end
      if (grant && !redirect_i) pcq[pq_wr] <= fetch_pc;
   end
   assert property (@(posedge clk_i) disable iff (rst_i) rvalid_i |-> (live != '0 || drop != '0));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios against an in-order memory model; a monitor
// scores every decode handshake and every posted point check against a queue of expectations.
module tb_instr_fetch_unit;
   logic clk = 0, rst_i = 1, redirect_i = 0, gnt_i = 0, rvalid_i = 0, rdy = 0;
   logic instr_ready_i, req_o, instr_valid_o;
   logic [31:0] redirect_addr_i = 0, rdata_i = 0, addr_o, instr_o, instr_pc_o;
   int checks = 0, errors = 0, pushed = 0, popped = 0, cyc = 0;
   int gnt_mode = 0, lat_min = 1, lat_max = 1, last_due = 0, start = 0;
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;
   mreq_t mq[$];
   chk_t dq[$];
   logic [31:0] exp_q[$];

   instr_fetch_unit #(.ADDR_W(32), .BOOT_ADDR(32'h0), .DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
      .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
      .instr_pc_o(instr_pc_o));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign instr_ready_i = rdy && (pushed != popped);

   // memory: grants recorded mid-cycle, responses in order, 1+ cycles later, data = addr>>2
   always @(negedge clk) begin : mem
      mreq_t m;
      if (rst_i) begin
         mq.delete();
         rvalid_i = 0;
         gnt_i = 0;
         last_due = 0;
      end else begin
         gnt_i = gnt_mode == 2 ? 1'($urandom_range(1)) : gnt_mode == 1;
         rvalid_i = 0;
         if (mq.size() != 0 && mq[0].due <= cyc) begin
            rvalid_i = 1;
            rdata_i = mq[0].addr >> 2;
            void'(mq.pop_front());
         end
         if (req_o && gnt_i) begin
            m.addr = addr_o;
            m.due = cyc + int'($urandom_range(lat_max, lat_min));
            if (m.due <= last_due) m.due = last_due + 1;
            last_due = m.due;
            mq.push_back(m);
         end
      end
   end

   always @(negedge clk) begin : mon
      chk_t c;
      logic [31:0] e;
      while (dq.size() != 0) begin
         c = dq.pop_front();
         checks++;
         if (c.act !== c.exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", c.name, c.act, c.exp);
         end
      end
      if (!rst_i && instr_valid_o && instr_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_instr: pc %h instr %h, nothing expected", instr_pc_o, instr_o);
         end else begin
            e = exp_q.pop_front();
            if (instr_pc_o !== e || instr_o !== (e >> 2)) begin
               errors++;
               $display("FAIL stream: pc %h instr %h, expected pc %h instr %h", instr_pc_o, instr_o, e, e >> 2);
            end
         end
         @(posedge clk);
         popped <= popped + 1;
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic post(string name, logic [31:0] act, logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.act = act;
      c.exp = exp;
      dq.push_back(c);
   endtask

   task automatic expect_pcs(logic [31:0] base, int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(base + 32'(4 * i));
         pushed++;
      end
   endtask

   task automatic drain(string name, int max);
      int k = 0;
      while (pushed != popped && k < max) begin
         tick();
         k++;
      end
      post(name, 32'(pushed - popped), 0);
      if (pushed != popped) begin
         exp_q.delete();
         pushed = popped;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values and streaming at one instruction per cycle
      tick(2);
      post("rst_req", 32'(req_o), 0);
      post("rst_valid", 32'(instr_valid_o), 0);
      post("rst_instr", instr_o, 0);
      post("rst_pc", instr_pc_o, 0);
      gnt_mode = 1;
      rdy = 1;
      expect_pcs(32'h0, 8);
      rst_i = 0;
      start = cyc;
      #1;
      post("boot_req", 32'(req_o), 1);
      post("boot_addr", addr_o, 32'h0);
      drain("stream_left", 40);
      post("stream_cycles", 32'(cyc - start), 10);
      // backpressure: exactly DEPTH buffered, then resume at 0x10
      rst_i = 1;
      rdy = 0;
      tick(2);
      rst_i = 0;
      tick(10);
      post("bp_req", 32'(req_o), 0);
      post("bp_valid", 32'(instr_valid_o), 1);
      gnt_mode = 0;
      rdy = 1;
      expect_pcs(32'h0, 4);
      drain("bp_left", 20);
      tick(2);
      post("bp_empty", 32'(instr_valid_o), 0);
      post("bp_resume_req", 32'(req_o), 1);
      post("bp_resume_addr", addr_o, 32'h10);
      gnt_mode = 1;
      expect_pcs(32'h10, 4);
      drain("resume_left", 30);
      // redirect with two buffered and two in flight
      rst_i = 1;
      rdy = 0;
      tick(2);
      rst_i = 0;
      tick(2);
      lat_min = 3;
      lat_max = 3;
      tick(2);
      post("pre_redir_valid", 32'(instr_valid_o), 1);
      post("pre_redir_req", 32'(req_o), 0);
      redirect_i = 1;
      redirect_addr_i = 32'h103;
      tick();
      redirect_i = 0;
      post("redir_valid", 32'(instr_valid_o), 0);
      post("redir_req", 32'(req_o), 1);
      post("redir_addr", addr_o, 32'h100);
      lat_min = 1;
      lat_max = 1;
      rdy = 1;
      expect_pcs(32'h100, 6);
      drain("redir_left", 40);
      // random grants and latency 1-3, 1000 consecutive instructions
      rst_i = 1;
      tick(2);
      rst_i = 0;
      gnt_mode = 2;
      lat_max = 3;
      expect_pcs(32'h0, 1000);
      for (int i = 0; i < 9000 && pushed != popped; i++) begin
         rdy = 1'($urandom_range(1));
         tick();
      end
      rdy = 1;
      drain("random_left", 200);
      // address wrap through the top of the address space
      gnt_mode = 1;
      lat_max = 1;
      redirect_i = 1;
      redirect_addr_i = 32'hFFFF_FFF8;
      tick();
      redirect_i = 0;
      post("wrap_addr", addr_o, 32'hFFFF_FFF8);
      expect_pcs(32'hFFFF_FFF8, 4);
      drain("wrap_left", 60);
      // asynchronous reset with the FIFO full
      tick(10);
      post("full_valid", 32'(instr_valid_o), 1);
      post("full_req", 32'(req_o), 0);
      #2 rst_i = 1;
      #1;
      post("async_valid", 32'(instr_valid_o), 0);
      post("async_req", 32'(req_o), 0);
      post("async_pc", instr_pc_o, 0);
      tick(2);
      rst_i = 0;
      #1;
      post("restart_req", 32'(req_o), 1);
      post("restart_addr", addr_o, 32'h0);
      expect_pcs(32'h0, 4);
      drain("restart_left", 40);
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
